// File: rtl/arb_client_pkg.sv
// Shared types for the arbiter client front end: FSM state encoding and a
// width helper for counters that must stay at least one bit wide.
package arb_client_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_client_if_sync_fifo.sv
// Small synchronous FIFO: registered count/full/empty, head word read
// combinationally from storage at the read pointer.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = arb_client_pkg::cnt_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;   // extra MSB is the wrap bit
    logic [CW-1:0] count_nxt;
    logic          wr_en, rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    // next occupancy from this cycle's push/pop
    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // storage write; contents need no reset since empty gates everything
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

    // pointers and registered occupancy flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/arb_client_if.sv
// Requester-side front end for a round-robin arbiter. Buffers local words,
// requests while data is pending, drains a bounded burst per grant pulse.
// Optional grant-wait timeout flag: define ARB_CLIENT_TIMEOUT_EN.
module arb_client_if
    import arb_client_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          req,
    input  logic          grant,
    output logic          bus_valid,
    output logic [DW-1:0] bus_data,
    output logic          bus_last,
    output logic          busy,
    output logic          err_timeout
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = cnt_w(MAX_BURST);

    state_t        state, state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          ready_q;
    logic          push, xfer, last_beat;
    logic          err_q;

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (xfer),
        .din   (in_data),
        .head  (bus_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign xfer      = (state == XFER);
    // a same-cycle push does not change count until the edge, so it cannot
    // cancel a last beat decided on count==1
    assign last_beat = xfer && ((beat_cnt == BW'(MAX_BURST-1)) || (count == CW'(1)));
    assign push      = in_valid && in_ready;

    // everything is forced low while rst is high so a reset mid-burst
    // truncates immediately, without a bus_last
    assign in_ready    = ready_q && !full && !rst;
    assign req         = (state == REQ) && !rst;
    assign bus_valid   = xfer && !rst;
    assign bus_last    = last_beat && !rst;
    assign busy        = ((state != IDLE) || !empty) && !rst;
    assign err_timeout = err_q && !rst;

    // in_ready is held off for the first cycle after reset release
    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= 1'b1;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state; grants outside REQ are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = REQ;
            REQ:     if (grant)  state_nxt = XFER;
            XFER:    if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // beat counter: runs during XFER, parked at zero otherwise
    always_ff @(posedge clk) begin
        if (rst || !xfer)  beat_cnt <= '0;
        else if (!last_beat) beat_cnt <= beat_cnt + BW'(1);
    end

`ifdef ARB_CLIENT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] wait_cnt;

    // count consecutive REQ cycles; flag is sticky, req is never withdrawn
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == REQ) begin
            if (wait_cnt != TW'(TIMEOUT))   wait_cnt <= wait_cnt + TW'(1);
            if (wait_cnt == TW'(TIMEOUT-1)) err_q    <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign err_q          = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_arb_client_if.sv
// Bench for arb_client_if: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the client.
module tb_arb_client_if;
    localparam int DW = 8, DEPTH = 4, MB = 2, TO = 8;

    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, grant = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, req, bus_valid, bus_last, busy, err_timeout;
    logic [DW-1:0] bus_data;

    arb_client_if #(.DW(DW), .DEPTH(DEPTH), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .req(req), .grant(grant), .bus_valid(bus_valid),
        .bus_data(bus_data), .bus_last(bus_last), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // model: buffered words, phase (0 idle, 1 requesting, 2 bursting),
    // beats already sent this burst, ready-after-reset, timeout bookkeeping
    logic [DW-1:0] q [$];
    int  phase = 0, sent = 0, req_run = 0;
    bit  rdy = 0, err = 0;
    bit  prev_g = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // drive one cycle of inputs, check outputs, advance the model
    task automatic step(input bit v, input logic [DW-1:0] d, input bit g, input bit r);
        bit e_rdy, e_req, e_bv, e_last, e_busy, e_err, pushed;
        int n, old_phase;
        in_valid = v; in_data = d; grant = g; rst = r;
        prev_g = g;
        #1;
        n      = q.size();
        e_rdy  = !r && rdy && (n < DEPTH);
        e_req  = !r && (phase == 1);
        e_bv   = !r && (phase == 2);
        e_last = e_bv && ((sent + 1 == MB) || (n == 1));
        e_busy = !r && ((phase != 0) || (n != 0));
        e_err  = !r && err;
        chk("in_ready",    32'(in_ready),    32'(e_rdy));
        chk("req",         32'(req),         32'(e_req));
        chk("bus_valid",   32'(bus_valid),   32'(e_bv));
        chk("bus_last",    32'(bus_last),    32'(e_last));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("err_timeout", 32'(err_timeout), 32'(e_err));
        if (e_bv) chk("bus_data", 32'(bus_data), 32'(q[0]));
        if (r) begin
            q.delete(); phase = 0; sent = 0; rdy = 0; err = 0; req_run = 0;
        end else begin
            pushed    = v && e_rdy;
            old_phase = phase;
            if (old_phase == 0 && n != 0) phase = 1;
            if (old_phase == 1 && g) begin phase = 2; sent = 0; end
            if (old_phase == 2) begin
                if (e_last) phase = 0;
                else        sent++;
            end
            if (e_bv)   void'(q.pop_front());
            if (pushed) q.push_back(d);
            rdy = 1;
`ifdef ARB_CLIENT_TIMEOUT_EN
            if (old_phase == 1) begin
                req_run++;
                if (req_run >= TO) err = 1;
            end else begin
                req_run = 0;
            end
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0);
    endtask

    // bounded wait for the model to be requesting
    task automatic wait_req();
        int k = 0;
        while (phase != 1 && k < 20) begin step(0, '0, 0, 0); k++; end
        if (phase != 1) chk("wait_req_expired", 0, 1);
    endtask

    initial begin
        @(posedge clk); #1;
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        idle(2);

        // single word; grant once req is up
        step(1, 8'hA5, 0, 0);
        wait_req();
        step(0, '0, 1, 0);
        idle(3);
        chk("single_drained", 32'(q.size()), 0);

        // four words, two bursts of two; extra word refused while full
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 0);
        step(1, 8'h55, 0, 0);
        chk("full_count", 32'(q.size()), 4);
        wait_req();
        step(0, '0, 1, 0);
        step(1, 8'h66, 0, 0);      // refused, still full on first beat
        step(1, 8'h77, 0, 0);      // accepted on the second pop
        wait_req();
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);         // spurious grant on the last beat
        idle(1);
        wait_req();
        step(0, '0, 1, 0);
        idle(3);
        chk("order_drained", 32'(q.size()), 0);

        // spurious grant in idle
        step(0, '0, 1, 0);
        idle(2);

        // reset on the second beat of a burst
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        wait_req();
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("reset_flushed", 32'(q.size()), 0);

        // grant withheld past the timeout, then served
        step(1, 8'h99, 0, 0);
        idle(12);
        step(0, '0, 1, 0);
        idle(3);
        step(0, '0, 0, 1);
        idle(2);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bit v, g, r;
            v = ($urandom_range(0, 1) == 1);
            g = 0;
            if (!prev_g) begin
                if (phase == 1 && $urandom_range(0, 2) == 0) g = 1;
                else if ($urandom_range(0, 19) == 0)         g = 1;
            end
            r = ($urandom_range(0, 199) == 0);
            step(v, DW'($urandom), g, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
